// File: rtl/conv2d_sched.sv
// conv2d_sched: per-channel weight load, gap-free pixel burst and pipeline drain for one conv core.
// Optional z-strobe count checker is built when CONV2D_SCHED_ZCHK_EN is defined.
module conv2d_sched #(
  parameter int C_WIDTH   = 9,
  parameter int C_HEIGHT  = 9,
  parameter int C_CH      = 8,
  parameter int KS        = 3,
  parameter int DRAIN_CYC = 40
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [C_WIDTH-1:0]          cfg_width,
  input  logic [C_HEIGHT-1:0]         cfg_height,
  input  logic [C_CH-1:0]             cfg_nch,
  output logic                        busy,
  output logic                        done,
  output logic                        wt_req,
  output logic [C_CH-1:0]             wt_ch,
  input  logic                        wt_vld,
  input  logic [KS*KS*32-1:0]         wt_data,
  input  logic [C_WIDTH+C_HEIGHT-1:0] src_level,
  output logic                        param_ena,
  output logic [KS*KS*32-1:0]         param_weight,
  output logic [C_WIDTH-1:0]          param_width_in,
  output logic                        pxl_ena_x,
  input  logic                        pxl_ena_y,
  input  logic                        pxl_ena_z,
  output logic                        psum_rd,
  output logic                        y_zero,
  output logic                        psum_wr,
  output logic                        out_wr,
  output logic                        err
);

  localparam int PW = C_WIDTH + C_HEIGHT;
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYC - 1);
  localparam logic [C_CH-1:0] CH_ONE     = C_CH'(1);

  typedef enum logic [2:0] {IDLE, FETCH, PARAM, WAIT_SRC, STREAM, DRAIN} state_t;

  state_t            state_r;
  logic [C_CH-1:0]    ch_r;
  logic [C_CH-1:0]    nch_r;
  logic [C_WIDTH-1:0] width_r;
  logic [PW-1:0]      wh_r;
  logic [PW-1:0]      pix_cnt_r;
  logic [DW-1:0]      drain_cnt_r;
  logic [PW-1:0]      cfg_wh_s;
  logic               last_ch_s;

  assign cfg_wh_s  = {{C_HEIGHT{1'b0}}, cfg_width} * {{C_WIDTH{1'b0}}, cfg_height};
  assign last_ch_s = (ch_r == (nch_r - CH_ONE));

  // Partial sums are sourced from zero on the first channel and routed to the output on the last.
  assign y_zero  = pxl_ena_y & (ch_r == '0);
  assign psum_rd = pxl_ena_y & (ch_r != '0);
  assign psum_wr = pxl_ena_z & ~last_ch_s;
  assign out_wr  = pxl_ena_z & last_ch_s;

  // Channel sequencing FSM with registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      ch_r           <= '0;
      nch_r          <= '0;
      width_r        <= '0;
      wh_r           <= '0;
      pix_cnt_r      <= '0;
      drain_cnt_r    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      wt_req         <= 1'b0;
      wt_ch          <= '0;
      param_ena      <= 1'b0;
      param_weight   <= '0;
      param_width_in <= '0;
      pxl_ena_x      <= 1'b0;
    end else begin
      param_ena <= 1'b0;
      done      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            width_r <= cfg_width;
            nch_r   <= cfg_nch;
            wh_r    <= cfg_wh_s;
            ch_r    <= '0;
            wt_ch   <= '0;
            wt_req  <= 1'b1;
            busy    <= 1'b1;
            state_r <= FETCH;
          end
        end
        FETCH: begin
          if (wt_vld) begin
            param_weight   <= wt_data;
            param_width_in <= width_r;
            param_ena      <= 1'b1;
            wt_req         <= 1'b0;
            state_r        <= PARAM;
          end
        end
        PARAM: begin
          state_r <= WAIT_SRC;
        end
        // The whole plane must already be buffered: a gap would restart the core's line delays.
        WAIT_SRC: begin
          if (src_level >= wh_r) begin
            pxl_ena_x <= 1'b1;
            pix_cnt_r <= wh_r - PW'(1);
            state_r   <= STREAM;
          end
        end
        STREAM: begin
          if (pix_cnt_r == '0) begin
            pxl_ena_x   <= 1'b0;
            drain_cnt_r <= DRAIN_LOAD;
            state_r     <= DRAIN;
          end else begin
            pix_cnt_r <= pix_cnt_r - PW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt_r == '0) begin
            if (last_ch_s) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= IDLE;
            end else begin
              ch_r    <= ch_r + CH_ONE;
              wt_ch   <= ch_r + CH_ONE;
              wt_req  <= 1'b1;
              state_r <= FETCH;
            end
          end else begin
            drain_cnt_r <= drain_cnt_r - DW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef CONV2D_SCHED_ZCHK_EN
  logic [PW-1:0] zcnt_r;
  logic [PW-1:0] zcnt_next_s;
  logic          err_r;
  logic          early_z_s;
  logic          drain_exit_s;

  assign zcnt_next_s  = zcnt_r + {{(PW-1){1'b0}}, pxl_ena_z};
  assign drain_exit_s = (state_r == DRAIN) && (drain_cnt_r == '0);
  assign early_z_s    = pxl_ena_z && ((state_r == FETCH) || (state_r == PARAM) || (state_r == WAIT_SRC));

  // Per-channel z strobe count; err latches on a short/long channel or a stray early strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zcnt_r <= '0;
      err_r  <= 1'b0;
    end else begin
      if (state_r == PARAM) begin
        zcnt_r <= '0;
      end else begin
        zcnt_r <= zcnt_next_s;
      end
      if (early_z_s || (drain_exit_s && (zcnt_next_s != wh_r))) begin
        err_r <= 1'b1;
      end
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_conv2d_sched.sv
// Self-checking bench for conv2d_sched: stub core, weight responder and a count/timing reference model.
module tb_conv2d_sched;
  localparam int DRAIN = 40;
  localparam int ZLAT  = 37;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [8:0]   cfg_width = 9'd0;
  logic [8:0]   cfg_height = 9'd0;
  logic [7:0]   cfg_nch = 8'd0;
  logic         busy, done, wt_req;
  logic [7:0]   wt_ch;
  logic         wt_vld = 1'b0;
  logic [287:0] wt_data = '0;
  logic [17:0]  src_level = 18'd0;
  logic         param_ena;
  logic [287:0] param_weight;
  logic [8:0]   param_width_in;
  logic         pxl_ena_x;
  logic         pxl_ena_y = 1'b0;
  logic         pxl_ena_z = 1'b0;
  logic         psum_rd, y_zero, psum_wr, out_wr, err;

  int n_cmp = 0;
  int n_fail = 0;

  logic [287:0] exp_wt [256];
  int cnt_x [256];
  int bursts [256];
  int cnt_yz [256];
  int cnt_rd [256];
  int cnt_wr [256];
  int cnt_out [256];
  int param_cyc [256];
  int last_x [256];
  int wch_log [256];
  int lvl_arr [8192];
  int n_param, n_done, first_x0;
  bit err_seen;

  always #5 clk = ~clk;

  conv2d_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_nch(cfg_nch),
    .busy(busy), .done(done), .wt_req(wt_req), .wt_ch(wt_ch),
    .wt_vld(wt_vld), .wt_data(wt_data), .src_level(src_level),
    .param_ena(param_ena), .param_weight(param_weight), .param_width_in(param_width_in),
    .pxl_ena_x(pxl_ena_x), .pxl_ena_y(pxl_ena_y), .pxl_ena_z(pxl_ena_z),
    .psum_rd(psum_rd), .y_zero(y_zero), .psum_wr(psum_wr), .out_wr(out_wr), .err(err)
  );

  // One job: the stub core answers each pixel with y two cycles later and z ZLAT cycles later.
  task automatic run_job(input int w, input int h, input int nch, input int wdly, input int lowv,
                         input int lowc, input bit poke, input bit drop_z, input int abort_ch);
    int wh, vld_at, vld_cyc, ch_now, n_req, budget, stop_at, exp_c, exp_first;
    bit prev_x, prev_req, poked, aborted;
    int yq[$];
    int zq[$];
    wh = w * h; vld_at = -1; vld_cyc = -10; ch_now = 0; n_req = 0; stop_at = -1;
    prev_x = 1'b0; prev_req = 1'b0; poked = 1'b0; aborted = 1'b0;
    budget = nch * (wh + wdly + 70) + lowc + 50;
    n_param = 0; n_done = 0; err_seen = 1'b0; first_x0 = -1;
    for (int k = 0; k < 256; k++) begin
      cnt_x[k] = 0; bursts[k] = 0; cnt_yz[k] = 0; cnt_rd[k] = 0; cnt_wr[k] = 0; cnt_out[k] = 0;
      param_cyc[k] = 0; last_x[k] = -1000; wch_log[k] = -1;
      exp_wt[k] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
    end
    cfg_width = 9'(w); cfg_height = 9'(h); cfg_nch = 8'(nch);
    @(posedge clk); #1;
    start = 1'b1; src_level = 18'd0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (poke && !poked && cnt_x[0] == 3) begin
        start = 1'b1; cfg_width = 9'd7; cfg_height = 9'd2; cfg_nch = 8'd5; poked = 1'b1;
      end
      wt_vld = 1'b0;
      if (c == vld_at) begin
        wt_vld = 1'b1; wt_data = exp_wt[wt_ch]; vld_at = -1;
      end else if (!wt_req && (c % 13 == 0)) begin
        wt_vld = 1'b1; wt_data = {9{$urandom()}};
      end
      pxl_ena_y = (yq.size() > 0) && (yq[0] == c);
      if (pxl_ena_y) void'(yq.pop_front());
      pxl_ena_z = (zq.size() > 0) && (zq[0] == c);
      if (pxl_ena_z) void'(zq.pop_front());
      src_level = (c <= lowc) ? 18'(lowv) : 18'(wh + int'($urandom_range(0, 3)));
      lvl_arr[c] = int'(src_level);
      #1;
      if (c == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end
      end
      if (wt_req && !prev_req) begin
        exp_c = (n_req == 0) ? 1 : last_x[n_req-1] + DRAIN + 1;
        n_cmp++;
        if (c !== exp_c) begin n_fail++; $display("FAIL wt_req_time: got cycle %0d want %0d", c, exp_c); end
        n_req++;
      end
      prev_req = wt_req;
      if (wt_req && wt_vld) begin
        wch_log[n_param] = int'(wt_ch); vld_cyc = c;
      end else if (wt_req && vld_at < 0) begin
        vld_at = c + wdly;
      end
      if (param_ena) begin
        ch_now = n_param;
        param_cyc[ch_now] = c;
        n_cmp++;
        if (c !== vld_cyc + 1) begin n_fail++; $display("FAIL param_time: got cycle %0d want %0d", c, vld_cyc + 1); end
        n_cmp++;
        if (param_weight !== exp_wt[ch_now]) begin
          n_fail++; $display("FAIL param_weight ch%0d: got %h want %h", ch_now, param_weight, exp_wt[ch_now]);
        end
        n_cmp++;
        if (param_width_in !== 9'(w)) begin n_fail++; $display("FAIL param_width: got %0d want %0d", param_width_in, w); end
        n_param++;
      end
      if (pxl_ena_x) begin
        if (!prev_x) begin
          bursts[ch_now]++;
          if (cnt_x[ch_now] == 0) begin
            exp_first = -1;
            for (int j = param_cyc[ch_now] + 1; j < c && exp_first < 0; j++)
              if (lvl_arr[j] >= wh) exp_first = j + 1;
            if (ch_now == 0) first_x0 = c;
            n_cmp++;
            if (c !== exp_first) begin n_fail++; $display("FAIL first_x ch%0d: got cycle %0d want %0d", ch_now, c, exp_first); end
          end
        end
        cnt_x[ch_now]++;
        last_x[ch_now] = c;
        yq.push_back(c + 2);
        if (!(drop_z && cnt_x[ch_now] == 1)) zq.push_back(c + ZLAT);
      end
      prev_x = pxl_ena_x;
      if (y_zero) cnt_yz[ch_now]++;
      if (psum_rd) cnt_rd[ch_now]++;
      if (psum_wr) cnt_wr[ch_now]++;
      if (out_wr) cnt_out[ch_now]++;
      if (err) err_seen = 1'b1;
      if (done) begin
        n_done++;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b want 0", busy); end
        n_cmp++;
        if (c !== last_x[nch-1] + DRAIN + 1) begin
          n_fail++; $display("FAIL done_time: got cycle %0d want %0d", c, last_x[nch-1] + DRAIN + 1);
        end
        if (stop_at < 0) stop_at = c + 3;
      end
      if (abort_ch >= 0 && ch_now == abort_ch && n_param > abort_ch && cnt_x[ch_now] == 5) begin
        rst = 1'b1; pxl_ena_y = 1'b0; pxl_ena_z = 1'b0; wt_vld = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, wt_req, wt_ch, param_ena, param_width_in, pxl_ena_x,
             psum_rd, y_zero, psum_wr, out_wr, err} !== 27'd0 || param_weight !== 288'd0) begin
          n_fail++; $display("FAIL mid_reset_outputs: busy=%b wt_req=%b wt_ch=%0d x=%b pw_in=%0d got nonzero want all 0",
                             busy, wt_req, wt_ch, pxl_ena_x, param_width_in);
        end
        aborted = 1'b1;
        break;
      end
      if (c == stop_at) break;
    end
    if (!aborted) begin
      n_cmp++;
      if (n_done !== 1) begin n_fail++; $display("FAIL done_count: got %0d want 1 (0 means timeout)", n_done); end
      n_cmp++;
      if (n_param !== nch) begin n_fail++; $display("FAIL param_count: got %0d want %0d", n_param, nch); end
      for (int k = 0; k < nch; k++) begin
        n_cmp++;
        if (wch_log[k] !== k || cnt_x[k] !== wh || bursts[k] !== 1) begin
          n_fail++; $display("FAIL channel_stream ch%0d: got wt_ch=%0d x=%0d bursts=%0d want wt_ch=%0d x=%0d bursts=1",
                             k, wch_log[k], cnt_x[k], bursts[k], k, wh);
        end
        n_cmp++;
        if (cnt_yz[k] !== ((k == 0) ? wh : 0) || cnt_rd[k] !== ((k != 0) ? wh : 0) ||
            cnt_wr[k] !== ((k != nch-1) ? wh - int'(drop_z) : 0) ||
            cnt_out[k] !== ((k == nch-1) ? wh - int'(drop_z) : 0)) begin
          n_fail++; $display("FAIL channel_strobes ch%0d: got yz=%0d rd=%0d wr=%0d out=%0d want yz=%0d rd=%0d wr=%0d out=%0d",
                             k, cnt_yz[k], cnt_rd[k], cnt_wr[k], cnt_out[k],
                             (k == 0) ? wh : 0, (k != 0) ? wh : 0,
                             (k != nch-1) ? wh - int'(drop_z) : 0, (k == nch-1) ? wh - int'(drop_z) : 0);
        end
      end
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b want 0", busy); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({busy, done, wt_req, wt_ch, param_ena, param_width_in, pxl_ena_x,
         psum_rd, y_zero, psum_wr, out_wr, err} !== 27'd0 || param_weight !== 288'd0) begin
      n_fail++; $display("FAIL reset_outputs: busy=%b wt_req=%b x=%b got nonzero want all 0", busy, wt_req, pxl_ena_x);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    n_cmp++;
    if (busy !== 1'b0 || wt_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b wt_req=%b want 0 0", busy, wt_req);
    end
  endtask

  task automatic test_single();
    run_job(4, 4, 1, 3, 0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_multi_channel();
    run_job(5, 3, 3, 2, 0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_src_wait();
    run_job(4, 4, 1, 3, 10, 20, 1'b0, 1'b0, -1);
    n_cmp++;
    if (first_x0 !== 22) begin n_fail++; $display("FAIL src_wait_first_x: got cycle %0d want 22", first_x0); end
  endtask

  task automatic test_ignore_while_busy();
    run_job(4, 4, 2, 1, 0, 0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_mid_reset();
    run_job(4, 4, 2, 2, 0, 0, 1'b0, 1'b0, 1);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || pxl_ena_x !== 1'b0 || wt_req !== 1'b0) begin
      n_fail++; $display("FAIL held_reset: got busy=%b x=%b wt_req=%b want 0 0 0", busy, pxl_ena_x, wt_req);
    end
    rst = 1'b0;
    run_job(4, 4, 2, 1, 0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_job(int'($urandom_range(3, 6)), int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
              int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
              1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_job(3, 2, 2, 1, 0, 0, 1'b0, 1'b0, -1);
    run_job(6, 1, 1, 1, 0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_zcheck();
    bit exp_err;
`ifdef CONV2D_SCHED_ZCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    run_job(4, 4, 1, 2, 0, 0, 1'b0, 1'b1, -1);
    n_cmp++;
    if (err_seen !== exp_err) begin n_fail++; $display("FAIL zcheck_err: got %b want %b", err_seen, exp_err); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (err !== exp_err) begin n_fail++; $display("FAIL zcheck_sticky: got %b want %b", err, exp_err); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL zcheck_cleared: got %b want 0", err); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_channel();
    test_src_wait();
    test_ignore_while_busy();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_zcheck();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
